// File: rtl/pmp_pkg.sv
// Shared PMP types and helpers: cfg layout, address-matching modes, access kinds.
// Honours `PMP_TOR_EN` (TOR mode) when legalising cfg writes.
package pmp_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } pmp_mode_t;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_t a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_EXEC  = 2'd2
  } pmp_acc_t;

  // Turns a raw cfg byte into what the register actually stores.
  function automatic pmp_cfg_t pmp_cfg_legalize(input logic [7:0] raw);
    pmp_cfg_t c;
    c      = pmp_cfg_t'(raw);
    c.rsvd = 2'b00;
    if (c.w && !c.r) begin
      c.x = 1'b0;
      c.w = 1'b0;
    end
`ifndef PMP_TOR_EN
    if (c.a == PMP_TOR) c.a = PMP_OFF;
`endif
    return c;
  endfunction

  function automatic logic pmp_perm_ok(input pmp_cfg_t c, input logic [1:0] acc);
    case (pmp_acc_t'(acc))
      ACC_READ:  return c.r;
      ACC_WRITE: return c.w;
      ACC_EXEC:  return c.x;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pmp_checker_if.sv
// Request/response bus of the PMP checker; the core side is master, the checker is slave.
interface pmp_checker_if #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 3
);
  // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
  // the master holds its request fields stable while valid is high and ready is low.
  // rsp_valid_o pulses for exactly one cycle, the cycle after each transfer, with no backpressure.
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_type_i;
  logic              req_mmode_i;
  logic              rsp_valid_o;
  logic              rsp_fault_o;
  logic [IDX_W-1:0]  rsp_idx_o;

  modport master (
    output req_valid_i, req_addr_i, req_type_i, req_mmode_i,
    input  req_ready_o, rsp_valid_o, rsp_fault_o, rsp_idx_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_type_i, req_mmode_i,
    output req_ready_o, rsp_valid_o, rsp_fault_o, rsp_idx_o
  );
endinterface

// File: rtl/pmp_napot_decode.sv
// Turns one pmpaddr plus its mode into mask/match form for NA4 and NAPOT regions.
module pmp_napot_decode
  import pmp_pkg::*;
#(
  parameter int W = 30
) (
  input  logic [W-1:0] addr_i,
  input  pmp_mode_t    mode_i,
  output logic [W-1:0] mask_o,
  output logic [W-1:0] match_o
);

  logic [W-1:0] dont_care;

  always_comb begin
    mask_o    = '0;
    match_o   = '0;
    // Trailing ones plus the first zero above them; all-ones wraps to a full don't-care.
    dont_care = addr_i ^ (addr_i + W'(1));
    case (mode_i)
      PMP_NA4: begin
        mask_o  = '1;
        match_o = addr_i;
      end
      PMP_NAPOT: begin
        mask_o  = ~dont_care;
        match_o = addr_i & ~dont_care;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pmp_checker.sv
// PMP checker: CSR-written entries, registered region decode, one check per cycle.
// Define PMP_TOR_EN to build TOR support and the TOR lock-propagation rule.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 32,
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int AW     = ADDR_W - 2
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_reset_i,
  input  logic             csr_we_i,
  input  logic             csr_sel_i,
  input  logic [IDX_W-1:0] csr_idx_i,
  input  logic [AW-1:0]    csr_wdata_i,
  output logic [AW-1:0]    csr_rdata_o,
  pmp_checker_if.slave     bus
);

  // Architectural registers, as seen by the CSR unit.
  pmp_cfg_t      cfg_q   [ENTRIES];
  pmp_cfg_t      cfg_d   [ENTRIES];
  logic [AW-1:0] addr_q  [ENTRIES];
  logic [AW-1:0] addr_d  [ENTRIES];
  logic [ENTRIES-1:0] addr_locked;

  // Decoded copies, one edge behind the architectural registers.
  pmp_cfg_t      dcfg_q  [ENTRIES];
  pmp_cfg_t      dcfg_d  [ENTRIES];
  logic [AW-1:0] mask_q  [ENTRIES];
  logic [AW-1:0] mask_d  [ENTRIES];
  logic [AW-1:0] match_q [ENTRIES];
  logic [AW-1:0] match_d [ENTRIES];
`ifdef PMP_TOR_EN
  logic [AW-1:0] tor_lo_q [ENTRIES];
  logic [AW-1:0] tor_lo_d [ENTRIES];
  logic [AW-1:0] tor_hi_q [ENTRIES];
  logic [AW-1:0] tor_hi_d [ENTRIES];
`endif

  logic             pend_q, pend_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;

  logic [AW-1:0]      req_word;
  logic [ENTRIES-1:0] hit;
  logic               win_any;
  logic [IDX_W-1:0]   win_idx;
  pmp_cfg_t           win_cfg;
  logic               allow;
  logic               accept;
  logic               unused_bits;

  assign req_word    = bus.req_addr_i[ADDR_W-1:2];
  assign unused_bits = ^{bus.req_addr_i[1:0], win_cfg.rsvd, win_cfg.a};

  // An address register is frozen by its own lock, or by a locked TOR entry above using it as base.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      addr_locked[i] = cfg_q[i].l;
`ifdef PMP_TOR_EN
      if (i + 1 < ENTRIES) begin
        addr_locked[i] = cfg_q[i].l |
                         (cfg_q[(i + 1) % ENTRIES].l && (cfg_q[(i + 1) % ENTRIES].a == PMP_TOR));
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      cfg_d[i]  = cfg_q[i];
      addr_d[i] = addr_q[i];
      if (csr_we_i && (csr_idx_i == IDX_W'(i))) begin
        if (!csr_sel_i) begin
          if (!cfg_q[i].l) cfg_d[i] = pmp_cfg_legalize(csr_wdata_i[7:0]);
        end else if (!addr_locked[i]) begin
          addr_d[i] = csr_wdata_i;
        end
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (csr_idx_i == IDX_W'(i)) begin
        csr_rdata_o = csr_sel_i ? addr_q[i] : {{(AW-8){1'b0}}, cfg_q[i]};
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_dec
    pmp_napot_decode #(.W(AW)) u_dec (
      .addr_i (addr_q[g]),
      .mode_i (cfg_q[g].a),
      .mask_o (mask_d[g]),
      .match_o(match_d[g])
    );
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      dcfg_d[i] = cfg_q[i];
`ifdef PMP_TOR_EN
      tor_hi_d[i] = addr_q[i];
      tor_lo_d[i] = (i == 0) ? '0 : addr_q[(i + ENTRIES - 1) % ENTRIES];
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      hit[i] = 1'b0;
      case (dcfg_q[i].a)
        PMP_NA4, PMP_NAPOT: hit[i] = ((req_word & mask_q[i]) == match_q[i]);
`ifdef PMP_TOR_EN
        // An empty or inverted range simply never satisfies both bounds.
        PMP_TOR: hit[i] = (req_word >= tor_lo_q[i]) && (req_word < tor_hi_q[i]);
`endif
        default: ;
      endcase
    end
  end

  // Scan from the top down so the lowest-indexed hit is the one left standing.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_cfg = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
        win_cfg = dcfg_q[i];
      end
    end
    if (win_any) begin
      allow = (bus.req_mmode_i && !win_cfg.l) || pmp_perm_ok(win_cfg, bus.req_type_i);
    end else begin
      allow = bus.req_mmode_i;
    end
  end

  assign bus.req_ready_o = ~pend_q;
  assign accept          = bus.req_valid_i & ~pend_q;

  always_comb begin
    pend_d      = csr_we_i;
    rsp_valid_d = accept;
    rsp_fault_d = rsp_fault_q;
    rsp_idx_d   = rsp_idx_q;
    if (accept) begin
      rsp_fault_d = ~allow;
      rsp_idx_d   = win_idx;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cfg_q[i]   <= '0;
        addr_q[i]  <= '0;
        dcfg_q[i]  <= '0;
        mask_q[i]  <= '0;
        match_q[i] <= '0;
`ifdef PMP_TOR_EN
        tor_lo_q[i] <= '0;
        tor_hi_q[i] <= '0;
`endif
      end
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      dcfg_q      <= dcfg_d;
      mask_q      <= mask_d;
      match_q     <= match_d;
`ifdef PMP_TOR_EN
      tor_lo_q    <= tor_lo_d;
      tor_hi_q    <= tor_hi_d;
`endif
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_fault_o = rsp_fault_q;
  assign bus.rsp_idx_o   = rsp_idx_q;

endmodule

// File: tb/tb_pmp_checker.sv
// Directed bench for pmp_checker: CSR programming, region matching, priority, lock and timing.
module tb_pmp_checker;
  localparam logic [1:0] RD = 2'd0;
  localparam logic [1:0] WR = 2'd1;
  localparam logic [1:0] EX = 2'd2;
  localparam logic U = 1'b0;
  localparam logic M = 1'b1;

  logic        cpu_clock_i;
  logic        cpu_reset_i;
  logic        csr_we;
  logic        csr_sel;
  logic [2:0]  csr_idx;
  logic [29:0] csr_wdata;
  logic [29:0] csr_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0]  got, exp_r;
  logic [29:0] rd, exp_rd;

  pmp_checker_if #(.ADDR_W(32), .IDX_W(3)) bus ();

  pmp_checker #(.ENTRIES(8), .ADDR_W(32)) dut (
    .cpu_clock_i(cpu_clock_i),
    .cpu_reset_i(cpu_reset_i),
    .csr_we_i   (csr_we),
    .csr_sel_i  (csr_sel),
    .csr_idx_i  (csr_idx),
    .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata),
    .bus        (bus)
  );

  // clock / reset
  initial cpu_clock_i = 1'b0;
  always #5 cpu_clock_i = ~cpu_clock_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks: every task starts and ends at a falling edge
  task automatic csr_write(input logic sel, input int idx, input logic [29:0] data);
    csr_we = 1'b1; csr_sel = sel; csr_idx = idx[2:0]; csr_wdata = data;
    @(negedge cpu_clock_i);
    csr_we = 1'b0;
    @(negedge cpu_clock_i);
  endtask

  task automatic csr_read(input logic sel, input int idx, output logic [29:0] val);
    csr_sel = sel; csr_idx = idx[2:0];
    #1;
    val = csr_rdata;
  endtask

  task automatic access(input logic [31:0] addr, input logic [1:0] typ, input logic mm,
                        output logic [4:0] res);
    bus.req_valid_i = 1'b1; bus.req_addr_i = addr; bus.req_type_i = typ; bus.req_mmode_i = mm;
    @(negedge cpu_clock_i);
    bus.req_valid_i = 1'b0;
    res = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o};
  endtask

  task automatic test_reset();
    cpu_reset_i = 1'b1;
    repeat (3) @(negedge cpu_clock_i);
    got = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o}; exp_r = 5'b0_0_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL reset_rsp: got %b want %b", got, exp_r); end
    csr_read(1'b0, 0, rd); exp_rd = 30'h0;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL reset_cfg0: got %h want %h", rd, exp_rd); end
    csr_read(1'b1, 7, rd); exp_rd = 30'h0;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL reset_addr7: got %h want %h", rd, exp_rd); end
    cpu_reset_i = 1'b0;
    @(negedge cpu_clock_i);
    n_vec++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
  endtask

  task automatic test_no_match();
    access(32'h0000_1000, RD, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL nomatch_u: got %b want %b", got, exp_r); end
    access(32'h0000_1000, RD, M, got); exp_r = 5'b1_0_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL nomatch_m: got %b want %b", got, exp_r); end
  endtask

  task automatic test_napot();
    csr_write(1'b1, 0, 30'h0FF);
    csr_write(1'b0, 0, 30'h19);
    csr_read(1'b0, 0, rd); exp_rd = 30'h19;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL napot_cfg_rb: got %h want %h", rd, exp_rd); end
    access(32'h0000_07FC, RD, U, got); exp_r = 5'b1_0_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL napot_rd_7fc: got %b want %b", got, exp_r); end
    access(32'h0000_07FC, WR, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL napot_wr_7fc: got %b want %b", got, exp_r); end
    access(32'h0000_0800, RD, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL napot_rd_800: got %b want %b", got, exp_r); end
    access(32'h0000_07FC, WR, M, got); exp_r = 5'b1_0_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL napot_mbypass: got %b want %b", got, exp_r); end
  endtask

  task automatic test_priority();
    csr_write(1'b1, 1, 30'h07F);
    csr_write(1'b0, 1, 30'h1B);
    csr_write(1'b1, 0, 30'h040);
    csr_write(1'b0, 0, 30'h10);
    access(32'h0000_0100, WR, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL prio_wr_100: got %b want %b", got, exp_r); end
    access(32'h0000_0104, WR, U, got); exp_r = 5'b1_0_001;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL prio_wr_104: got %b want %b", got, exp_r); end
    access(32'h0000_03FC, RD, U, got); exp_r = 5'b1_0_001;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL prio_rd_3fc: got %b want %b", got, exp_r); end
    access(32'h0000_0400, RD, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL prio_rd_400: got %b want %b", got, exp_r); end
  endtask

  task automatic test_legalize();
    csr_write(1'b0, 5, 30'h7E);
    csr_read(1'b0, 5, rd); exp_rd = 30'h18;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL legal_cfg5: got %h want %h", rd, exp_rd); end
  endtask

  task automatic test_tor();
    csr_write(1'b0, 0, 30'h00);
    csr_write(1'b1, 0, 30'h100);
    csr_write(1'b1, 1, 30'h200);
    csr_write(1'b0, 1, 30'h0C);
    csr_read(1'b0, 1, rd);
`ifdef PMP_TOR_EN
    exp_rd = 30'h0C;
`else
    exp_rd = 30'h04;
`endif
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL tor_cfg1_rb: got %h want %h", rd, exp_rd); end
    access(32'h0000_07FC, EX, U, got);
`ifdef PMP_TOR_EN
    exp_r = 5'b1_0_001;
`else
    exp_r = 5'b1_1_000;
`endif
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL tor_ex_7fc: got %b want %b", got, exp_r); end
    access(32'h0000_0800, EX, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL tor_ex_800: got %b want %b", got, exp_r); end
    access(32'h0000_03FC, EX, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL tor_ex_3fc: got %b want %b", got, exp_r); end
`ifdef PMP_TOR_EN
    access(32'h0000_07FC, RD, U, got); exp_r = 5'b1_1_001;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL tor_rd_7fc: got %b want %b", got, exp_r); end
`endif
  endtask

  task automatic test_concurrent();
    csr_write(1'b1, 3, 30'h400);
    // cycle W: cfg write and request together
    csr_we = 1'b1; csr_sel = 1'b0; csr_idx = 3'd3; csr_wdata = 30'h11;
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h0000_1000; bus.req_type_i = RD; bus.req_mmode_i = U;
    @(negedge cpu_clock_i);
    csr_we = 1'b0;
    got = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o}; exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL conc_old_cfg: got %b want %b", got, exp_r); end
    n_vec++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL conc_ready_w1: got %b want 0", bus.req_ready_o); end
    csr_read(1'b0, 3, rd); exp_rd = 30'h11;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL conc_arch_rb: got %h want %h", rd, exp_rd); end
    @(negedge cpu_clock_i);
    n_vec++; if (bus.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL conc_stall: got %b want 0", bus.rsp_valid_o); end
    n_vec++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL conc_ready_w2: got %b want 1", bus.req_ready_o); end
    @(negedge cpu_clock_i);
    bus.req_valid_i = 1'b0;
    got = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o}; exp_r = 5'b1_0_011;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL conc_new_cfg: got %b want %b", got, exp_r); end
  endtask

  task automatic test_back_to_back();
    csr_we = 1'b1; csr_sel = 1'b1; csr_idx = 3'd4; csr_wdata = 30'h10;
    @(negedge cpu_clock_i);
    csr_wdata = 30'h20;
    n_vec++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready_1: got %b want 0", bus.req_ready_o); end
    @(negedge cpu_clock_i);
    csr_we = 1'b0;
    n_vec++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready_2: got %b want 0", bus.req_ready_o); end
    @(negedge cpu_clock_i);
    n_vec++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready_3: got %b want 1", bus.req_ready_o); end
    csr_read(1'b1, 4, rd); exp_rd = 30'h20;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL b2b_addr4: got %h want %h", rd, exp_rd); end
    // three requests in consecutive cycles
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h0000_1000; bus.req_type_i = RD; bus.req_mmode_i = U;
    @(negedge cpu_clock_i);
    got = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o}; exp_r = 5'b1_0_011;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL b2b_req0: got %b want %b", got, exp_r); end
    bus.req_type_i = WR;
    @(negedge cpu_clock_i);
    got = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o}; exp_r = 5'b1_1_011;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL b2b_req1: got %b want %b", got, exp_r); end
    bus.req_addr_i = 32'h0000_2000; bus.req_type_i = RD;
    @(negedge cpu_clock_i);
    bus.req_valid_i = 1'b0;
    got = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o}; exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL b2b_req2: got %b want %b", got, exp_r); end
    @(negedge cpu_clock_i);
    n_vec++; if (bus.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_pulse: got %b want 0", bus.rsp_valid_o); end
  endtask

  task automatic test_lock();
    csr_write(1'b1, 2, 30'h200);
    csr_write(1'b0, 2, 30'h91);
    csr_read(1'b0, 2, rd); exp_rd = 30'h91;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL lock_cfg_rb: got %h want %h", rd, exp_rd); end
    access(32'h0000_0800, WR, M, got); exp_r = 5'b1_1_010;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL lock_m_wr: got %b want %b", got, exp_r); end
    access(32'h0000_0800, RD, M, got); exp_r = 5'b1_0_010;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL lock_m_rd: got %b want %b", got, exp_r); end
    csr_we = 1'b1; csr_sel = 1'b1; csr_idx = 3'd2; csr_wdata = 30'h333;
    @(negedge cpu_clock_i);
    csr_we = 1'b0;
    n_vec++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL lock_ready_w1: got %b want 0", bus.req_ready_o); end
    csr_read(1'b1, 2, rd); exp_rd = 30'h200;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL lock_addr_rb: got %h want %h", rd, exp_rd); end
    @(negedge cpu_clock_i);
    n_vec++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL lock_ready_w2: got %b want 1", bus.req_ready_o); end
    csr_write(1'b0, 2, 30'h00);
    csr_read(1'b0, 2, rd); exp_rd = 30'h91;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL lock_cfg_keep: got %h want %h", rd, exp_rd); end
  endtask

  task automatic test_tor_lock();
    csr_write(1'b1, 5, 30'h300);
    csr_write(1'b0, 6, 30'h89);
    csr_write(1'b1, 5, 30'h123);
    csr_read(1'b0, 6, rd);
`ifdef PMP_TOR_EN
    exp_rd = 30'h89;
`else
    exp_rd = 30'h81;
`endif
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL torlock_cfg6: got %h want %h", rd, exp_rd); end
    csr_read(1'b1, 5, rd);
`ifdef PMP_TOR_EN
    exp_rd = 30'h300;
`else
    exp_rd = 30'h123;
`endif
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL torlock_addr5: got %h want %h", rd, exp_rd); end
  endtask

  task automatic test_reset_mid();
    bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h0000_1000; bus.req_type_i = RD; bus.req_mmode_i = U;
    cpu_reset_i = 1'b1;
    @(negedge cpu_clock_i);
    bus.req_valid_i = 1'b0;
    got = {bus.rsp_valid_o, bus.rsp_fault_o, bus.rsp_idx_o}; exp_r = 5'b0_0_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL midrst_rsp: got %b want %b", got, exp_r); end
    @(negedge cpu_clock_i);
    cpu_reset_i = 1'b0;
    @(negedge cpu_clock_i);
    csr_read(1'b0, 2, rd); exp_rd = 30'h0;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL midrst_cfg2: got %h want %h", rd, exp_rd); end
    csr_write(1'b1, 2, 30'h55);
    csr_read(1'b1, 2, rd); exp_rd = 30'h55;
    n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL midrst_unlock: got %h want %h", rd, exp_rd); end
    access(32'h0000_1000, RD, U, got); exp_r = 5'b1_1_000;
    n_vec++; if (got !== exp_r) begin n_err++; $display("FAIL midrst_nomatch: got %b want %b", got, exp_r); end
  endtask

  initial begin
    cpu_reset_i = 1'b1;
    csr_we = 1'b0; csr_sel = 1'b0; csr_idx = 3'd0; csr_wdata = '0;
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_type_i = RD; bus.req_mmode_i = U;
    test_reset();
    test_no_match();
    test_napot();
    test_priority();
    test_legalize();
    test_tor();
    test_concurrent();
    test_back_to_back();
    test_lock();
    test_tor_lock();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
